// File: rtl/regfile.sv
// Integer register file: x1..x31 storage, one write port, two registered read ports A/B.
// Define REGFILE_BYPASS_EN for write-first forwarding; default build is read-first.
module regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              IR,
  input  logic                     stall,
  input  logic [XLEN-1:0]          data,
  input  logic [$clog2(NREGS)-1:0] address,
  output logic [XLEN-1:0]          A,
  output logic [XLEN-1:0]          B
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] a_d, a_q, b_d, b_q;
  logic [AW-1:0]   rs1, rs2;

  assign rs1 = IR[15 +: AW];
  assign rs2 = IR[20 +: AW];

  // Only the source-register fields matter here.
  logic unused_ir;
  assign unused_ir = ^{IR[31:20+AW], IR[14:0]};

  // x0 has no storage; address 0 therefore never matches a register.
  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else if (address == AW'(i)) begin
        regs_q[i] <= data;
      end
    end
  end

  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1 == AW'(i)) a_d = regs_q[i];
      if (rs2 == AW'(i)) b_d = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    // A nonzero address implies the matched source is not x0.
    if (address != '0 && address == rs1) a_d = data;
    if (address != '0 && address == rs2) b_d = data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (!stall) begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A = a_q;
  assign B = b_q;

endmodule

// File: tb/tb_regfile.sv
// Directed plus randomized scoreboard bench for regfile; honours REGFILE_BYPASS_EN.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR;
  logic        stall;
  logic [31:0] data;
  logic [4:0]  address;
  logic [31:0] A;
  logic [31:0] B;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];

  regfile dut (
    .clk     (clk),
    .rst     (rst),
    .IR      (IR),
    .stall   (stall),
    .data    (data),
    .address (address),
    .A       (A),
    .B       (B)
  );

  always #5 clk = ~clk;

  task automatic check_ab(input string tag, input logic [31:0] ea, input logic [31:0] eb);
    checks++;
    assert (A === ea) else begin
      failures++;
      $error("FAIL %s_A got=%h exp=%h", tag, A, ea);
    end
    checks++;
    assert (B === eb) else begin
      failures++;
      $error("FAIL %s_B got=%h exp=%h", tag, B, eb);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic cy(input logic [4:0] r1, input logic [4:0] r2, input logic st,
                    input logic [4:0] wa, input logic [31:0] wd,
                    input logic [31:0] ea, input logic [31:0] eb, input string tag);
    logic [31:0] ir;
    exp_t e;
    ir        = $urandom;
    ir[24:20] = r2;
    ir[19:15] = r1;
    IR        = ir;
    stall     = st;
    address   = wa;
    data      = wd;
    sb.push_back('{tag, ea, eb});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_ab(e.tag, e.a, e.b);
  endtask

  initial begin
    logic [31:0] m [32];
    logic [31:0] la, lb, ea, eb, wd;
    logic [4:0]  r1, r2, wa;
    logic        st;

    rst     = 1'b1;
    IR      = '0;
    stall   = 1'b0;
    data    = '0;
    address = '0;
    #3;
    check_ab("reset", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write then read, x0 reads, no-write encoding
    cy(0, 0, 0, 5, 32'hDEADBEEF, 32'h0, 32'h0, "wr_x5");
    cy(5, 0, 0, 0, 32'h12345678, 32'hDEADBEEF, 32'h0, "rd_x5");
    cy(0, 5, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF, "rd_x0_x5");

    // Same-edge hazard on both ports
    cy(0, 0, 0, 7, 32'h1, 32'h0, 32'h0, "wr_x7");
    cy(7, 5, 0, 7, 32'h2, Byp ? 32'h2 : 32'h1, 32'hDEADBEEF, "haz_a");
    cy(7, 7, 0, 0, 32'h0, 32'h2, 32'h2, "haz_next");
    cy(3, 9, 0, 9, 32'hCAFE, 32'h0, Byp ? 32'hCAFE : 32'h0, "haz_b");
    cy(9, 9, 0, 0, 32'h0, 32'hCAFE, 32'hCAFE, "dual");
    cy(0, 0, 0, 0, 32'hFFFFFFFF, 32'h0, 32'h0, "x0_nobyp");

    // Stall freezes outputs while writes still commit
    cy(0, 0, 0, 10, 32'hAA, 32'h0, 32'h0, "wr_x10");
    cy(10, 0, 0, 0, 32'h0, 32'hAA, 32'h0, "a_aa");
    cy(7, 9, 1, 3, 32'h55, 32'hAA, 32'h0, "stall1");
    cy(5, 10, 1, 3, 32'h55, 32'hAA, 32'h0, "stall2");
    cy(9, 7, 1, 3, 32'h55, 32'hAA, 32'h0, "stall3");
    cy(3, 9, 0, 0, 32'h0, 32'h55, 32'hCAFE, "unstall");

    // Asynchronous reset mid-cycle, then reset held across a write edge
    #2;
    rst = 1'b1;
    #1;
    check_ab("async_rst", 32'h0, 32'h0);
    address = 5'd5;
    data    = 32'hFFFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cy(5, 3, 0, 0, 32'h0, 32'h0, 32'h0, "post_rst");
    cy(9, 10, 0, 0, 32'h0, 32'h0, 32'h0, "post_rst2");

    // Randomized traffic against a reference model
    for (int i = 0; i < 32; i++) m[i] = '0;
    la = '0;
    lb = '0;
    for (int n = 0; n < 80; n++) begin
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      st = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) r1 = wa;
      if ($urandom_range(0, 3) == 0) r2 = wa;
      if (st) begin
        ea = la;
        eb = lb;
      end else begin
        ea = (Byp && wa != 0 && wa == r1) ? wd : m[r1];
        eb = (Byp && wa != 0 && wa == r2) ? wd : m[r2];
        la = ea;
        lb = eb;
      end
      if (wa != 0) m[wa] = wd;
      cy(r1, r2, st, wa, wd, ea, eb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
